// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter with a one-deep holding register; first start bit 1 cycle after an idle write.
// No backpressure: a write while busy with the holding register full is dropped and sets sticky overrun.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wdata,
   input  logic       ovr_clr,
   output logic       tx,
   output logic       busy,
   output logic       hold_full,
   output logic       tx_done,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shifter, shift_nxt;
   logic [7:0]    hold_reg, hold_nxt;
   logic          hold_full_nxt;
   logic          overrun_nxt;
   logic          tx_nxt;
   logic          bit_end;
   logic          frame_end;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign frame_end = (state == STOP) && bit_end;
   assign busy      = (state != IDLE);
   assign tx_done   = frame_end;

   always_comb begin
      state_nxt     = state;
      baud_nxt      = baud_cnt;
      bit_nxt       = bit_idx;
      shift_nxt     = shifter;
      hold_nxt      = hold_reg;
      hold_full_nxt = hold_full;
      overrun_nxt   = overrun & ~ovr_clr;
      tx_nxt        = 1'b1;

      if (state != IDLE) begin
         baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (wr_en) begin
               shift_nxt = wdata;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               bit_nxt   = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = {1'b0, shifter[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            // Back-to-back frames: the held byte wins over a same-cycle write,
            // which then refills the holding register instead of overrunning.
            if (bit_end) begin
               if (hold_full) begin
                  shift_nxt = hold_reg;
                  state_nxt = START;
                  if (wr_en) begin
                     hold_nxt = wdata;
                  end else begin
                     hold_full_nxt = 1'b0;
                  end
               end else if (wr_en) begin
                  shift_nxt = wdata;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (busy && !frame_end && wr_en) begin
         if (!hold_full) begin
            hold_nxt      = wdata;
            hold_full_nxt = 1'b1;
         end else begin
            overrun_nxt = 1'b1;
         end
      end

      // tx is registered from the next-state view so the line changes with the state.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= 3'd0;
         shifter   <= 8'd0;
         hold_reg  <= 8'd0;
         hold_full <= 1'b0;
         overrun   <= 1'b0;
         tx        <= 1'b1;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_idx   <= bit_nxt;
         shifter   <= shift_nxt;
         hold_reg  <= hold_nxt;
         hold_full <= hold_full_nxt;
         overrun   <= overrun_nxt;
         tx        <= tx_nxt;
      end
   end

endmodule
